// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
//   Shared definitions for the convolution datapath (window generator and the
//   pe array top).
//   - PIX_W / WIN_W : pixel width and packed 3-pixel row-triplet width
//   - IMG_W_DEF / IMG_H_DEF : default frame geometry
//   - state_t : IDLE/RUN capture state of the window generator
//   - shift_in() : pushes a new pixel into a packed triplet (newest in [7:0])
// -----------------------------------------------------------------------------
package conv_pkg;

    localparam int PIX_W     = 8;
    localparam int WIN_W     = 3 * PIX_W;
    localparam int IMG_W_DEF = 64;
    localparam int IMG_H_DEF = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Oldest pixel (col c-2) falls off the top; newest (col c) enters at [7:0].
    function automatic logic [WIN_W-1:0] shift_in(
        input logic [WIN_W-1:0] win_in,
        input logic [PIX_W-1:0] pix_in
    );
        return {win_in[WIN_W-PIX_W-1:0], pix_in};
    endfunction

endpackage

// File: rtl/win3x3_gen_if.sv
// -----------------------------------------------------------------------------
// win3x3_gen_if
//   Pixel-in / window-out bundle of the 3x3 window generator.
//   - s_data/s_valid/s_ready : raster-order pixel stream into the generator
//   - p_top/p_mid/p_bot      : row triplets for rows r-2, r-1, r
//   - p_valid                : one-cycle strobe per complete window
//   Modports: slave = window generator, master = pixel source / window sink.
// -----------------------------------------------------------------------------
interface win3x3_gen_if;
    import conv_pkg::*;

    logic [PIX_W-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIN_W-1:0] p_top;
    logic [WIN_W-1:0] p_mid;
    logic [WIN_W-1:0] p_bot;
    logic             p_valid;

    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output p_top,
        output p_mid,
        output p_bot,
        output p_valid
    );

    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  p_top,
        input  p_mid,
        input  p_bot,
        input  p_valid
    );

endinterface

// File: rtl/line_buf.sv
// -----------------------------------------------------------------------------
// line_buf
//   One image line of storage indexed by column.
//   - clk   : clock
//   - we    : write enable (write on rising edge)
//   - addr  : column index, shared by read and write
//   - wdata : pixel to store
//   - rdata : combinational read of the currently stored pixel at addr
//   Read returns the old contents in the write cycle, which gives the
//   read-before-write behaviour the line chaining relies on. Contents are not
//   reset; every location is written before it is used for a valid window.
// -----------------------------------------------------------------------------
module line_buf #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/win3x3_gen.sv
// -----------------------------------------------------------------------------
// win3x3_gen
//   Turns a raster-order 8-bit pixel stream into 3x3 windows (valid-only, no
//   padding). An IMG_W x IMG_H frame gives (IMG_W-2)*(IMG_H-2) windows, each
//   delivered as three packed row triplets one clock after the pixel that
//   completes it.
//   Ports:
//   - clk, rstn  : clock, asynchronous active-low reset
//   - start      : one-cycle pulse arming capture of one frame (ignored in RUN)
//   - pix        : win3x3_gen_if.slave (pixel stream in, row triplets out)
//   - busy       : high while a frame is being captured
//   - frame_done : one-cycle pulse after the last pixel of the frame is taken
// -----------------------------------------------------------------------------
module win3x3_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    win3x3_gen_if.slave  pix,
    output logic         busy,
    output logic         frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            p_valid_q, p_valid_d;
    logic            frame_done_q, frame_done_d;

    logic            accept;
    logic            col_last;
    logic            row_last;
    logic [PIX_W-1:0] lb_a_rd;   // row r-1 at column c
    logic [PIX_W-1:0] lb_b_rd;   // row r-2 at column c

    // Pixel entering each row shifter: index 0 = top (r-2), 2 = bottom (r).
    logic [PIX_W-1:0] row_pix [3];

    // Never back-pressures mid-frame; readiness is purely the capture state.
    assign accept   = pix.s_valid && (state_q == RUN);
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));

    // ---------------------------------------------------------------------
    // Line buffers: LB_A holds the previous line, LB_B the one before that.
    // On each accepted pixel the old LB_A entry moves down into LB_B and the
    // new pixel replaces it, so the pair always holds rows r-1 and r-2.
    // ---------------------------------------------------------------------
    line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb_a (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (pix.s_data),
        .rdata (lb_a_rd)
    );

    line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (PIX_W)
    ) u_lb_b (
        .clk   (clk),
        .we    (accept),
        .addr  (col_q),
        .wdata (lb_a_rd),
        .rdata (lb_b_rd)
    );

    assign row_pix[0] = lb_b_rd;
    assign row_pix[1] = lb_a_rd;
    assign row_pix[2] = pix.s_data;

    // ---------------------------------------------------------------------
    // Row shifters. They are not flushed at a line wrap: the first two
    // windows of each line hold stale columns from the previous line, and
    // p_valid is simply withheld for c < 2.
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        logic [WIN_W-1:0] win_q, win_d;

        always_comb begin
            win_d = win_q;
            if (accept) begin
                win_d = shift_in(win_q, row_pix[gi]);
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                win_q <= '0;
            end else begin
                win_q <= win_d;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Capture FSM and raster counters
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        p_valid_d    = 1'b0;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end

            RUN: begin
                if (accept) begin
                    // A full window exists once two earlier rows and two
                    // earlier columns of the current line have been seen.
                    p_valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));

                    if (col_last) begin
                        col_d = '0;
                        row_d = row_last ? '0 : row_q + RW'(1);
                    end else begin
                        col_d = col_q + CW'(1);
                    end

                    if (col_last && row_last) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            p_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            p_valid_q    <= p_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign pix.s_ready = (state_q == RUN);
    assign busy        = (state_q == RUN);
    assign pix.p_top   = g_row[0].win_q;
    assign pix.p_mid   = g_row[1].win_q;
    assign pix.p_bot   = g_row[2].win_q;
    assign pix.p_valid = p_valid_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_win3x3_gen.sv
// -----------------------------------------------------------------------------
// tb_win3x3_gen
//   Bench for win3x3_gen. Two instances: a 4x4 frame generator (dut_a) and a
//   5x3 one (dut_b), both fed pixel(r,c) = 16*r + c. Expected windows are
//   built from that formula and queued when the completing pixel is driven;
//   windows seen on p_valid are queued on the other side and the two queues
//   are compared in order.
// -----------------------------------------------------------------------------
module tb_win3x3_gen;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic busy_a, busy_b, fd_a, fd_b;

    always #5 clk = ~clk;

    win3x3_gen_if ifa ();
    win3x3_gen_if ifb ();

    win3x3_gen #(.IMG_W(4), .IMG_H(4)) dut_a (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start_a),
        .pix        (ifa),
        .busy       (busy_a),
        .frame_done (fd_a)
    );

    win3x3_gen #(.IMG_W(5), .IMG_H(3)) dut_b (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start_b),
        .pix        (ifb),
        .busy       (busy_b),
        .frame_done (fd_b)
    );

    int errors = 0;
    int checks = 0;

    logic [71:0] exp_q [$];
    logic [71:0] obs_q [$];

    // Bench-side raster position model
    int m_w, m_h, m_r, m_c;
    int pv_err, fd_cnt, fd_bad;

    function automatic logic [7:0] px(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    function automatic logic [71:0] win(input int r, input int c);
        return {px(r-2, c-2), px(r-2, c-1), px(r-2, c),
                px(r-1, c-2), px(r-1, c-1), px(r-1, c),
                px(r,   c-2), px(r,   c-1), px(r,   c)};
    endfunction

    // One clock of stimulus on the selected DUT, plus output collection.
    task automatic step(input bit sel, input bit valid, input bit st);
        logic rdy, pv, fd;
        bit acc, qual;
        rdy = sel ? ifb.s_ready : ifa.s_ready;
        if (sel) begin
            ifb.s_valid = valid; ifb.s_data = px(m_r, m_c); start_b = st;
        end else begin
            ifa.s_valid = valid; ifa.s_data = px(m_r, m_c); start_a = st;
        end
        acc  = valid && rdy;
        qual = acc && (m_r >= 2) && (m_c >= 2);
        if (qual) exp_q.push_back(win(m_r, m_c));
        if (acc) begin
            if (m_c == m_w - 1) begin m_c = 0; m_r++; end
            else m_c++;
        end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        pv = sel ? ifb.p_valid : ifa.p_valid;
        fd = sel ? fd_b : fd_a;
        if (pv) obs_q.push_back(sel ? {ifb.p_top, ifb.p_mid, ifb.p_bot}
                                    : {ifa.p_top, ifa.p_mid, ifa.p_bot});
        if (pv !== qual) pv_err++;
        if (fd) begin
            fd_cnt++;
            if (!pv) fd_bad++;
        end
    endtask

    task automatic begin_frame(input bit sel, input int w, input int h);
        m_w = w; m_h = h; m_r = 0; m_c = 0;
        exp_q.delete(); obs_q.delete();
        pv_err = 0; fd_cnt = 0; fd_bad = 0;
        step(sel, 1'b1, 1'b1);   // s_valid high during start: must not be taken
    endtask

    // gap: three idle cycles before every odd raster-index pixel
    task automatic run_pixels(input bit sel, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap && (((m_r * m_w + m_c) % 2) == 1)) begin
                repeat (3) step(sel, 1'b0, 1'b0);
            end
            step(sel, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset();
        ifa.s_valid = 1'b0; ifa.s_data = '0;
        ifb.s_valid = 1'b0; ifb.s_data = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({ifa.p_top, ifa.p_mid, ifa.p_bot} !== 72'h0) begin errors++;
            $display("FAIL rst_win: got %h want 0", {ifa.p_top, ifa.p_mid, ifa.p_bot}); end
        checks++; if (ifa.p_valid !== 1'b0) begin errors++;
            $display("FAIL rst_pvalid: got %b want 0", ifa.p_valid); end
        checks++; if (ifa.s_ready !== 1'b0) begin errors++;
            $display("FAIL rst_sready: got %b want 0", ifa.s_ready); end
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b want 0", busy_a); end
        checks++; if (fd_a !== 1'b0) begin errors++;
            $display("FAIL rst_fdone: got %b want 0", fd_a); end
        checks++; if ({ifb.s_ready, ifb.p_valid, busy_b, fd_b} !== 4'b0) begin errors++;
            $display("FAIL rst_b_ctrl: got %b want 0000", {ifb.s_ready, ifb.p_valid, busy_b, fd_b}); end
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_continuous();
        logic [71:0] o, e;
        begin_frame(1'b0, 4, 4);
        run_pixels(1'b0, 15, 1'b0);
        checks++; if (busy_a !== 1'b1) begin errors++;
            $display("FAIL cont_busy_run: got %b want 1", busy_a); end
        run_pixels(1'b0, 1, 1'b0);
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL cont_busy_end: got %b want 0", busy_a); end
        checks++; if (obs_q.size() !== 4) begin errors++;
            $display("FAIL cont_count: got %0d want 4", obs_q.size()); end
        o = (obs_q.size() > 0) ? obs_q[0] : 72'h0;
        checks++; if (o !== 72'h000102_101112_202122) begin errors++;
            $display("FAIL cont_first: got %h want 000102101112202122", o); end
        o = (obs_q.size() > 0) ? obs_q[obs_q.size()-1] : 72'h0;
        checks++; if (o !== 72'h111213_212223_313233) begin errors++;
            $display("FAIL cont_last: got %h want 111213212223313233", o); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++;
                $display("FAIL cont_win: got %h want %h", o, e); end
        end
        checks++; if (pv_err !== 0) begin errors++;
            $display("FAIL cont_pvalid_timing: got %0d bad cycles want 0", pv_err); end
        checks++; if (fd_cnt !== 1 || fd_bad !== 0) begin errors++;
            $display("FAIL cont_fdone: got %0d pulses (%0d without p_valid) want 1 (0)", fd_cnt, fd_bad); end
        step(1'b0, 1'b0, 1'b0);
        checks++; if (busy_a !== 1'b0) begin errors++;
            $display("FAIL cont_busy_after: got %b want 0", busy_a); end
    endtask

    task automatic test_gaps();
        logic [71:0] o, e;
        begin_frame(1'b0, 4, 4);
        run_pixels(1'b0, 16, 1'b1);
        checks++; if (obs_q.size() !== 4) begin errors++;
            $display("FAIL gap_count: got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++;
                $display("FAIL gap_win: got %h want %h", o, e); end
        end
        checks++; if (pv_err !== 0) begin errors++;
            $display("FAIL gap_pvalid_timing: got %0d bad cycles want 0", pv_err); end
        checks++; if (fd_cnt !== 1 || fd_bad !== 0) begin errors++;
            $display("FAIL gap_fdone: got %0d pulses (%0d without p_valid) want 1 (0)", fd_cnt, fd_bad); end
    endtask

    task automatic test_idle_valid();
        logic [71:0] o, e;
        pv_err = 0;
        repeat (3) step(1'b0, 1'b1, 1'b0);
        checks++; if (ifa.s_ready !== 1'b0 || busy_a !== 1'b0) begin errors++;
            $display("FAIL idle_ready_busy: got %b%b want 00", ifa.s_ready, busy_a); end
        checks++; if (pv_err !== 0) begin errors++;
            $display("FAIL idle_pvalid: got %0d pulses want 0", pv_err); end
        begin_frame(1'b0, 4, 4);
        run_pixels(1'b0, 16, 1'b0);
        checks++; if (obs_q.size() !== 4) begin errors++;
            $display("FAIL idle_count: got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++;
                $display("FAIL idle_win: got %h want %h", o, e); end
        end
        checks++; if (pv_err !== 0 || fd_cnt !== 1) begin errors++;
            $display("FAIL idle_frame: got pv_err=%0d fd=%0d want 0 1", pv_err, fd_cnt); end
    endtask

    task automatic test_restart_ignored();
        logic [71:0] o, e;
        begin_frame(1'b0, 4, 4);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, (m_r == 1 && m_c == 2));
        end
        checks++; if (obs_q.size() !== 4) begin errors++;
            $display("FAIL restart_count: got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++;
                $display("FAIL restart_win: got %h want %h", o, e); end
        end
        checks++; if (fd_cnt !== 1 || pv_err !== 0) begin errors++;
            $display("FAIL restart_frame: got fd=%0d pv_err=%0d want 1 0", fd_cnt, pv_err); end
    endtask

    task automatic test_async_reset();
        logic [71:0] o, e;
        begin_frame(1'b0, 4, 4);
        run_pixels(1'b0, 11, 1'b0);   // model now sits at pixel (2,3)
        checks++; if (obs_q.size() !== 1) begin errors++;
            $display("FAIL arst_partial: got %0d windows want 1", obs_q.size()); end
        ifa.s_valid = 1'b1;
        ifa.s_data  = px(2, 3);
        #2 rstn = 1'b0;
        #1;
        checks++; if ({ifa.p_top, ifa.p_mid, ifa.p_bot} !== 72'h0) begin errors++;
            $display("FAIL arst_win: got %h want 0", {ifa.p_top, ifa.p_mid, ifa.p_bot}); end
        checks++; if ({ifa.p_valid, ifa.s_ready, busy_a, fd_a} !== 4'b0) begin errors++;
            $display("FAIL arst_ctrl: got %b want 0000", {ifa.p_valid, ifa.s_ready, busy_a, fd_a}); end
        @(posedge clk);
        #3 rstn = 1'b1;
        ifa.s_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({busy_a, fd_a} !== 2'b0) begin errors++;
            $display("FAIL arst_idle: got %b want 00", {busy_a, fd_a}); end
        begin_frame(1'b0, 4, 4);
        run_pixels(1'b0, 16, 1'b0);
        checks++; if (obs_q.size() !== 4) begin errors++;
            $display("FAIL arst_count: got %0d want 4", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++;
                $display("FAIL arst_win2: got %h want %h", o, e); end
        end
        checks++; if (fd_cnt !== 1 || pv_err !== 0) begin errors++;
            $display("FAIL arst_frame: got fd=%0d pv_err=%0d want 1 0", fd_cnt, pv_err); end
    endtask

    task automatic test_wide();
        logic [71:0] o, e;
        begin_frame(1'b1, 5, 3);
        run_pixels(1'b1, 15, 1'b0);
        checks++; if (obs_q.size() !== 3) begin errors++;
            $display("FAIL wide_count: got %0d want 3", obs_q.size()); end
        o = (obs_q.size() > 2) ? obs_q[2] : 72'h0;
        checks++; if (o[23:0] !== 24'h222324) begin errors++;
            $display("FAIL wide_third_bot: got %h want 222324", o[23:0]); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++;
                $display("FAIL wide_win: got %h want %h", o, e); end
        end
        checks++; if (fd_cnt !== 1 || fd_bad !== 0 || pv_err !== 0) begin errors++;
            $display("FAIL wide_frame: got fd=%0d fd_bad=%0d pv_err=%0d want 1 0 0", fd_cnt, fd_bad, pv_err); end
    endtask

    initial begin
        m_w = 4; m_h = 4; m_r = 0; m_c = 0;
        pv_err = 0; fd_cnt = 0; fd_bad = 0;
        test_reset();
        test_continuous();
        test_gaps();
        test_idle_valid();
        test_restart_ignored();
        test_async_reset();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
